// File: rtl/req_sched_arb_pkg.sv
// arb_pkg: shared types and defaults for the request scheduler/arbiter.
//   mode_e  - arbitration policy encoding as seen on the 2-bit mode port
//   state_e - arbiter FSM states
//   N_DEF, CNT_W_DEF - default requester count and error-counter width
package arb_pkg;

    localparam int N_DEF     = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        PRIORITY    = 2'b00,
        UNIQUE      = 2'b01,
        UNIQUE0     = 2'b10,
        ROUND_ROBIN = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/req_sched_arb_rr_pick.sv
// rr_pick: combinational rotating lowest-index priority encoder.
//   req       [N-1:0]          request vector
//   start_ptr [$clog2(N)-1:0]  index where the search begins (wraps N-1 -> 0)
//   hit                        any request found
//   idx       [$clog2(N)-1:0]  first asserted index at or after start_ptr
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start_ptr,
    output logic                 hit,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int unsigned    pos;
    logic [IW-1:0]  pos_idx;

    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // Modular wrap without '%' so non-power-of-two N stays cheap.
            pos = 32'(start_ptr) + i;
            if (pos >= 32'(N)) begin
                pos = pos - 32'(N);
            end
            pos_idx = IW'(pos);
            if (!hit && req[pos_idx]) begin
                hit = 1'b1;
                idx = pos_idx;
            end
        end
    end

endmodule

// File: rtl/req_sched_arb.sv
// req_sched_arb: single-resource arbiter with selectable policy and
// uniqueness / no-match error reporting.
//   clk, rst_n   clock, asynchronous active-low reset
//   mode  [1:0]  policy: PRIORITY, UNIQUE, UNIQUE0, ROUND_ROBIN
//   req   [N-1:0] request vector
//   chk          strobe demanding a decision this cycle
//   gnt   [N-1:0] registered one-hot grant
//   gnt_id       owner index, valid while gnt_vld
//   gnt_vld      a grant is held
//   multi_err    pulse: more than one request under UNIQUE/UNIQUE0
//   none_err     pulse: chk with no request (not under UNIQUE0)
//   err_cnt      saturating count of error pulses
module req_sched_arb
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         req,
    input  logic                 chk,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_vld,
    output logic                 multi_err,
    output logic                 none_err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int IW = $clog2(N);

    state_e         state_q, state_d;
    mode_e          mode_m;
    logic [IW-1:0]  rr_ptr, rr_ptr_d;
    logic [IW-1:0]  start_ptr;
    logic           pick_hit;
    logic [IW-1:0]  pick_idx;
    logic           multi_req;
    logic [N-1:0]   gnt_d;
    logic [IW-1:0]  gnt_id_d;
    logic           gnt_vld_d;
    logic           multi_d;
    logic           none_d;

    assign mode_m = mode_e'(mode);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req = (req & (req - 1'b1)) != '0;

    // PRIORITY and the UNIQUE variants are a rotating search anchored at 0.
    assign start_ptr = (mode_m == ROUND_ROBIN) ? rr_ptr : '0;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req       (req),
        .start_ptr (start_ptr),
        .hit       (pick_hit),
        .idx       (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        gnt_vld_d = gnt_vld;
        rr_ptr_d  = rr_ptr;
        multi_d   = 1'b0;
        none_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req == '0) begin
                    none_d = chk && (mode_m != UNIQUE0);
                end else if (((mode_m == UNIQUE) || (mode_m == UNIQUE0)) && multi_req) begin
                    multi_d = 1'b1;
                end else if (pick_hit) begin
                    gnt_d     = N'(1) << pick_idx;
                    gnt_id_d  = pick_idx;
                    gnt_vld_d = 1'b1;
                    state_d   = BUSY;
                    if (mode_m == ROUND_ROBIN) begin
                        rr_ptr_d = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    end
                end
            end
            BUSY: begin
                // Release drops to IDLE with no grant; that IDLE cycle is the
                // dead cycle before the next arbitration can land.
                if (!req[gnt_id]) begin
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_vld   <= 1'b0;
            rr_ptr    <= '0;
            multi_err <= 1'b0;
            none_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_vld   <= gnt_vld_d;
            rr_ptr    <= rr_ptr_d;
            multi_err <= multi_d;
            none_err  <= none_d;
            if ((multi_d || none_d) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_req_sched_arb.sv
module tb_req_sched_arb;
    import arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] req = '0;
    logic         chk = 1'b0;

    logic [N-1:0] gnt, gnt_s;
    logic [1:0]   gnt_id, gnt_id_s;
    logic         gnt_vld, gnt_vld_s;
    logic         multi_err, multi_err_s;
    logic         none_err, none_err_s;
    logic [7:0]   err_cnt;
    logic [1:0]   err_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Behavioural model: owner index (-1 = none), rr pointer, error counts.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_cnt2  = 0;
    bit m_me    = 0;
    bit m_ne    = 0;

    req_sched_arb #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .chk(chk),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld),
        .multi_err(multi_err), .none_err(none_err), .err_cnt(err_cnt)
    );

    req_sched_arb #(.N(N), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .chk(chk),
        .gnt(gnt_s), .gnt_id(gnt_id_s), .gnt_vld(gnt_vld_s),
        .multi_err(multi_err_s), .none_err(none_err_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_cnt2  = 0;
        m_me    = 0;
        m_ne    = 0;
    endtask

    task automatic model_edge(input int md, input logic [N-1:0] r, input bit c);
        int ones;
        ones = $countones(r);
        m_me = 0;
        m_ne = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) m_owner = -1;
        end else if (ones == 0) begin
            m_ne = c && (md != 2);
        end else if ((md == 1 || md == 2) && ones > 1) begin
            m_me = 1;
        end else begin
            int start;
            start = (md == 3) ? m_ptr : 0;
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && r[(start + i) % N]) m_owner = (start + i) % N;
            end
            if (md == 3) m_ptr = (m_owner + 1) % N;
        end
        if (m_me || m_ne) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic step(input int md, input logic [N-1:0] r, input bit c);
        mode = md[1:0];
        req  = r;
        chk  = c;
        @(posedge clk);
        model_edge(md, r, c);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (cmp_en) begin
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            expect_eq("gnt", gnt, eg);
            expect_eq("gnt_vld", gnt_vld, m_owner >= 0);
            if (m_owner >= 0) expect_eq("gnt_id", gnt_id, m_owner);
            expect_eq("multi_err", multi_err, m_me);
            expect_eq("none_err", none_err, m_ne);
            expect_eq("err_cnt", err_cnt, m_cnt);
            expect_eq("sat_gnt", gnt_s, eg);
            expect_eq("sat_gnt_vld", gnt_vld_s, m_owner >= 0);
            expect_eq("sat_multi_err", multi_err_s, m_me);
            expect_eq("sat_none_err", none_err_s, m_ne);
            expect_eq("sat_err_cnt", err_cnt_s, m_cnt2);
        end
    end

    initial begin
        logic [N-1:0] r;
        int md;
        bit c;

        do_reset();
        cmp_en = 1;
        expect_eq("rst_gnt", gnt, 0);
        expect_eq("rst_gnt_vld", gnt_vld, 0);
        expect_eq("rst_gnt_id", gnt_id, 0);
        expect_eq("rst_err_cnt", err_cnt, 0);
        expect_eq("rst_multi_none", {multi_err, none_err}, 0);

        // Priority grant, release, dead cycle, next grant.
        step(PRIORITY, 4'b0110, 0);
        expect_eq("pri_gnt", gnt, 4'b0010);
        expect_eq("pri_gnt_id", gnt_id, 1);
        step(PRIORITY, 4'b0100, 0);
        expect_eq("pri_release", gnt, 4'b0000);
        step(PRIORITY, 4'b0100, 0);
        expect_eq("pri_regrant", gnt, 4'b0100);
        step(PRIORITY, 4'b0000, 0);
        expect_eq("pri_idle", gnt, 4'b0000);

        // Round robin with all requesters, each releasing in turn.
        step(ROUND_ROBIN, 4'b1111, 0);
        expect_eq("rr_first", gnt, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            step(ROUND_ROBIN, 4'b1111 & ~(N'(1) << ((k - 1) % N)), 0);
            expect_eq("rr_gap", gnt, 0);
            step(ROUND_ROBIN, 4'b1111, 0);
            expect_eq("rr_order", gnt_id, k % N);
        end
        step(ROUND_ROBIN, 4'b0000, 0);

        // Uniqueness violations.
        step(UNIQUE, 4'b1001, 0);
        expect_eq("uniq_multi", multi_err, 1);
        expect_eq("uniq_gnt", gnt, 0);
        expect_eq("uniq_cnt", err_cnt, 1);
        step(UNIQUE, 4'b0000, 0);
        expect_eq("uniq_pulse_end", multi_err, 0);
        step(UNIQUE0, 4'b1001, 0);
        expect_eq("uniq0_multi", multi_err, 1);
        expect_eq("uniq0_cnt", err_cnt, 2);

        // No-match on chk.
        step(UNIQUE, 4'b0000, 1);
        expect_eq("none_uniq", none_err, 1);
        expect_eq("none_uniq_cnt", err_cnt, 3);
        step(UNIQUE0, 4'b0000, 1);
        expect_eq("none_uniq0", none_err, 0);
        expect_eq("none_uniq0_cnt", err_cnt, 3);

        // Narrow counter saturation.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(UNIQUE, 4'b1001, 0);
            expect_eq("sat_cnt", err_cnt_s, (k < 3) ? k : 3);
        end
        step(UNIQUE, 4'b0000, 0);

        // Asynchronous reset while BUSY, then rr pointer back at 0.
        step(ROUND_ROBIN, 4'b1111, 0);
        expect_eq("pre_rst_gnt", gnt, 4'b0001);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        expect_eq("async_rst_gnt", gnt, 0);
        expect_eq("async_rst_vld", gnt_vld, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(ROUND_ROBIN, 4'b1111, 0);
        expect_eq("post_rst_rr", gnt, 4'b0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            md = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) r = '0;
            else if ($urandom_range(0, 1) == 0) r = req;
            else r = N'($urandom);
            c = ($urandom_range(0, 3) == 0);
            step(md, r, c);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_sched_arb.md
REQ_SCHED_ARB -- requirements
Module: req_sched_arb

Interface
REQ-001 Parameter N, default 4, is the number of requesters (2..16).
REQ-002 Parameter CNT_W, default 8, is the width of the error counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port mode  input  2  selects arbitration policy: 00 PRIORITY, 01 UNIQUE, 10 UNIQUE0, 11 ROUND_ROBIN.
REQ-006 Port req  input  N  carries the request vector, with bit i for requester i.
REQ-007 Port chk  input  1  is a one-cycle strobe demanding a decision this cycle.
REQ-008 Port gnt  output  N  is the registered one-hot grant, and is all-zero when no requester owns the resource.
REQ-009 Port gnt_id  output  $clog2(N)  is the index of the current owner, and is valid only while gnt_vld=1.
REQ-010 Port gnt_vld  output  1  is high while any grant is held.
REQ-011 Port multi_err  output  1  is a one-cycle pulse flagging a uniqueness violation.
REQ-012 Port none_err  output  1  is a one-cycle pulse flagging a no-match on chk.
REQ-013 Port err_cnt  output  CNT_W  is a saturating count of multi_err plus none_err events.

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY; arbitration occurs only in IDLE.
REQ-015 In IDLE, mode SHALL be sampled every cycle; the policy in effect is latched at grant time, and mode changes while BUSY do not affect the owner.
REQ-016 In IDLE with PRIORITY, the lowest-index asserted req SHALL win: gnt is set at cycle t+1 for req sampled at cycle t, and the FSM moves to BUSY.
REQ-017 In IDLE with ROUND_ROBIN, the search SHALL start at rr_ptr, wrapping from N-1 to 0; on a grant to index k, rr_ptr becomes (k+1) mod N.
REQ-018 In IDLE with UNIQUE or UNIQUE0, exactly one asserted req SHALL be granted as in REQ-016.
REQ-019 In IDLE with UNIQUE or UNIQUE0 and two or more asserted req bits:
  - no grant is issued;
  - the FSM stays in IDLE;
  - multi_err pulses at t+1.
REQ-020 When chk=1 in IDLE and req is all-zero, none_err SHALL pulse at t+1 for PRIORITY, UNIQUE and ROUND_ROBIN; UNIQUE0 suppresses it.
REQ-021 When chk=1 arrives while BUSY, it SHALL be ignored (no error).
REQ-022 In BUSY, gnt SHALL hold while req[gnt_id]=1; other requests are ignored.
REQ-023 When req[gnt_id]=0 in BUSY, gnt, gnt_vld and gnt_id SHALL clear at the next edge and the FSM returns to IDLE.
REQ-024 The first cycle back in IDLE SHALL be a dead cycle with no grant, so the earliest new grant is 2 cycles after release.
REQ-025 err_cnt SHALL increment by 1 per error pulse and saturate at 2^CNT_W-1 without wrapping.
REQ-026 multi_err and none_err SHALL be mutually exclusive by construction, since one needs req≠0 and the other req=0.
REQ-027 gnt SHALL never have more than one bit set.

Reset
REQ-028 While rst_n=0, the block SHALL immediately hold:
  - state IDLE;
  - gnt=0, gnt_id=0, gnt_vld=0;
  - multi_err=0, none_err=0;
  - err_cnt=0, rr_ptr=0.
REQ-029 Reset asserted mid-BUSY SHALL drop the grant asynchronously; after deassertion, the first arbitration uses rr_ptr=0.

Structure
REQ-030 Package arb_pkg SHALL hold:
  - typedef enum mode_e {PRIORITY, UNIQUE, UNIQUE0, ROUND_ROBIN};
  - typedef enum state_e {IDLE, BUSY};
  - default constants N_DEF=4 and CNT_W_DEF=8.
REQ-031 One sub-module, rr_pick, SHALL be combinational: a rotating lowest-index priority encoder taking (req, start_ptr) and returning (hit, idx); PRIORITY reuses it with start_ptr=0.

Verification
REQ-032 mode=PRIORITY, req=4'b0110 → at t+1 gnt=4'b0010, gnt_id=1; drop req[1] → gnt=0 the next cycle, then gnt=4'b0100 two cycles after the release.
REQ-033 mode=ROUND_ROBIN, req=4'b1111 held, each owner releases for one cycle in turn → grant order is 0,1,2,3,0.
REQ-034 mode=UNIQUE, req=4'b1001 → multi_err=1 for one cycle, gnt stays 0, err_cnt=1; with UNIQUE0 the same stimulus also gives multi_err.
REQ-035 req=0 with chk=1: mode=UNIQUE → none_err pulse and err_cnt increments; mode=UNIQUE0 → no pulse and err_cnt unchanged.
REQ-036 CNT_W=2: five multi_err events → err_cnt stays at 3.
REQ-037 rst_n=0 while BUSY → gnt=0 immediately, without waiting for an edge; after release with req=4'b1111 in ROUND_ROBIN → first grant is to index 0.
